// File: rtl/ifetch_unit.sv
// ifetch_unit: LEGv8 instruction fetch stage.
// Holds the fetch PC, runs one outstanding request at a time to instruction
// memory (req/ack), and buffers returned words in a 2-entry queue that is
// presented to decode with valid/ready. A taken branch redirects the PC,
// empties the queue and discards the response of any in-flight request.
//
// Ports:
//   clk, reset         - single clock, synchronous active-high reset
//   imem_req/addr      - request and word address toward instruction memory
//   imem_ack/rdata     - one-cycle ack pulse with the returned word
//   branch_taken/target- redirect from execute (target bits [1:0] ignored)
//   instr_valid/ready  - queue head handshake toward decode
//   instr_out/pc       - head instruction word and its PC
module ifetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [63:0] instr_pc
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

    localparam logic [1:0] FULL = 2'(QDEPTH);

    state_t      r_state;
    logic [63:0] r_fetch_pc;
    logic [63:0] r_stale_addr;   // address of the request orphaned by a redirect
    logic [31:0] r_q_instr [2];
    logic [63:0] r_q_pc    [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_next_count;
    logic [63:0] w_target;
    logic        w_unused_tgt_lsbs;

    assign w_target          = {branch_target[63:2], 2'b00};
    assign w_unused_tgt_lsbs = ^branch_target[1:0];

    assign w_push       = imem_ack && (r_state == S_REQ) && !branch_taken;
    assign w_pop        = instr_valid && instr_ready && !branch_taken;
    assign w_next_count = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // While a stale request is still live, its address must stay on the bus
    // even though fetch_pc already points at the branch target.
    assign imem_req    = (r_state != S_IDLE);
    assign imem_addr   = (r_state == S_DISCARD) ? r_stale_addr : r_fetch_pc;
    assign instr_valid = (r_count != 2'd0);
    assign instr_out   = r_q_instr[r_rptr];
    assign instr_pc    = r_q_pc[r_rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_stale_addr <= RESET_PC;
            r_count      <= 2'd0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
        end else if (branch_taken) begin
            r_count    <= 2'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_fetch_pc <= w_target;
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    // Acked now: the word is dropped and the target is
                    // requested next. Not acked: wait out the stale response.
                    if (imem_ack) begin
                        r_state <= S_REQ;
                    end else begin
                        r_state      <= S_DISCARD;
                        r_stale_addr <= r_fetch_pc;
                    end
                end
                S_DISCARD: r_state <= imem_ack ? S_REQ : S_DISCARD;
                default:   r_state <= S_IDLE;
            endcase
        end else begin
            if (w_push) begin
                r_q_instr[r_wptr] <= imem_rdata;
                r_q_pc[r_wptr]    <= r_fetch_pc;
                r_wptr            <= ~r_wptr;
                r_fetch_pc        <= r_fetch_pc + 64'd4;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= w_next_count;
            case (r_state)
                S_IDLE: if (r_count < FULL) r_state <= S_REQ;
                // Only stop issuing when the word just taken fills the queue.
                S_REQ: if (imem_ack && (w_next_count >= FULL)) r_state <= S_IDLE;
                S_DISCARD: if (imem_ack) r_state <= S_REQ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A single outstanding request against a 2-entry queue can never overflow.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && (r_count == FULL)));

endmodule
